// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply controller: op codes, FSM states
// and small op-classification helpers.
package hilo_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MTHI  = 4'd1,
        OP_MTLO  = 4'd2,
        OP_MULT  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MSUB  = 4'd5,
        OP_MULTU = 4'd6
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_MULTU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/mult_seq32.sv
// Sequential unsigned shift-add multiplier: one partial-product step per
// enabled cycle, with a down-counter tracking the remaining steps.
module mult_seq32 #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic [CW-1:0]      count
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // The multiplicand shifts left while the multiplier shifts right, so bit 0
    // of the multiplier always selects whether the current weight is added.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            count   <= '0;
        end else if (load) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            product <= '0;
            count   <= CW'(WIDTH);
        end else if (step) begin
            if (mplier[0])
                product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register file with a multi-cycle signed/unsigned multiply and
// multiply-accumulate/subtract, controlled by an IDLE/CALC/FIX state machine.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             Abort,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state, next_state;
    op_t                op_q;
    logic               sign_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;
    logic               start_ok, mul_load, mul_step, commit;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] product, fixed, acc, result;
    logic [CW-1:0]      count;

    // Abort wins over a coincident Start, so a flushed instruction never issues.
    assign start_ok = Start && !Abort && (state == S_IDLE);
    assign mag_a    = (is_signed_op(Op) && inA[WIDTH-1]) ? -inA : inA;
    assign mag_b    = (is_signed_op(Op) && inB[WIDTH-1]) ? -inB : inB;

    mult_seq32 #(.WIDTH(WIDTH), .CW(CW)) u_mult (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .load    (mul_load),
        .step    (mul_step),
        .a       (mag_a),
        .b       (mag_b),
        .product (product),
        .count   (count)
    );

    always_comb begin
        next_state = state;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok && is_mul(Op)) begin
                    mul_load   = 1'b1;
                    next_state = S_CALC;
                end
            end
            S_CALC: begin
                if (Abort) begin
                    next_state = S_IDLE;
                end else begin
                    mul_step = 1'b1;
                    if (count == CW'(1))
                        next_state = S_FIX;
                end
            end
            S_FIX: begin
                next_state = S_IDLE;
                if (!Abort)
                    commit = 1'b1;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        acc   = {hi_q, lo_q};
        fixed = sign_q ? -product : product;
        case (op_q)
            OP_MADD: result = acc + fixed;
            OP_MSUB: result = acc - fixed;
            default: result = fixed;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= S_IDLE;
            op_q   <= OP_NOP;
            sign_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= commit;
            if (mul_load) begin
                op_q   <= op_t'(Op);
                sign_q <= is_signed_op(Op) && (inA[WIDTH-1] ^ inB[WIDTH-1]);
            end
            if (commit)
                {hi_q, lo_q} <= result;
            else if (start_ok && Op == OP_MTHI)
                hi_q <= inA;
            else if (start_ok && Op == OP_MTLO)
                lo_q <= inA;
        end
    end

    assign Busy = (state != S_IDLE);
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed vector table, multi-cycle
// corner sequences, and random ops checked against a plain-arithmetic model.
module tb_hilo_muldiv_ctrl;

    localparam logic [3:0] MTHI = 4'd1, MTLO = 4'd2, MULT = 4'd3,
                           MADD = 4'd4, MSUB = 4'd5, MULTU = 4'd6;

    logic        Clk, Rst_n, Start, Abort, Busy, Done;
    logic [3:0]  Op;
    logic [31:0] inA, inB, Hi, Lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] mhi, mlo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, expHi, expLo;
    } vec_t;
    vec_t vecs[9];

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .inA(inA), .inB(inB),
        .Abort(Abort), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [63:0] refModel(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
        longint sp;
        logic [63:0] up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (op)
            MULT:    return sp;
            MADD:    return acc + sp;
            MSUB:    return acc - sp;
            default: return up;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One Start pulse; Done must never be high right after an issuing edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; Op = op; inA = a; inB = b;
        tick();
        Start = 1'b0;
        checkOutput("done_low_after_start", Done, 0);
    endtask

    task automatic waitDone(input string name, input int already, input logic [31:0] eh, input logic [31:0] el);
        int n = already;
        while (Busy && n < 100) begin
            n++;
            tick();
        end
        checkOutput({name, "_busy_cycles"}, n, 33);
        checkOutput({name, "_done"}, Done, 1);
        checkOutput({name, "_hilo"}, {Hi, Lo}, {eh, el});
    endtask

    task automatic runMul(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        applyStimulus(op, a, b);
        waitDone(name, 0, eh, el);
    endtask

    task automatic runSimple(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] eh, input logic [31:0] el);
        applyStimulus(op, a, 32'h0);
        checkOutput({name, "_hilo"}, {Hi, Lo}, {eh, el});
        checkOutput({name, "_busy"}, Busy, 0);
    endtask

    initial begin
        int doneSeen;
        logic [63:0] e;
        logic [3:0] rop;
        logic [31:0] ra, rb;

        vecs[0] = '{MTHI,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{MTLO,  32'h12345678, 32'h0, 32'hDEADBEEF, 32'h12345678};
        vecs[2] = '{MULT,  32'hFFFFFFFF, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[3] = '{MULTU, 32'hFFFFFFFF, 32'h7, 32'h00000006, 32'hFFFFFFF9};
        vecs[4] = '{MTHI,  32'h0,        32'h0, 32'h00000000, 32'hFFFFFFF9};
        vecs[5] = '{MTLO,  32'd10,       32'h0, 32'h00000000, 32'd10};
        vecs[6] = '{MADD,  32'd3,        32'd4, 32'h00000000, 32'd22};
        vecs[7] = '{MSUB,  32'd5,        32'd5, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[8] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        Rst_n = 1'b0; Start = 1'b0; Abort = 1'b0; Op = 4'd0; inA = '0; inB = '0;
        #12;
        checkOutput("reset_hilo", {Hi, Lo}, 64'h0);
        checkOutput("reset_busy_done", {Busy, Done}, 2'b00);
        Rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].op == MTHI || vecs[i].op == MTLO)
                runSimple($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].expHi, vecs[i].expLo);
            else
                runMul($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo);
        end

        // Start in the Done cycle is accepted.
        runSimple("start_in_done", MTLO, 32'h77, 32'h40000000, 32'h77);

        // Starts while busy (MTHI, then a different MULT) are ignored.
        applyStimulus(MULT, 32'h80000000, 32'h80000000);
        Start = 1'b1; Op = MTHI; inA = 32'h55;
        tick();
        Op = MULT; inA = 32'd1; inB = 32'd1;
        tick();
        Start = 1'b0;
        waitDone("ignored_start", 2, 32'h40000000, 32'h0);

        // Abort during CALC.
        runSimple("pre_hi", MTHI, 32'd1, 32'd1, 32'h0);
        runSimple("pre_lo", MTLO, 32'd2, 32'd1, 32'd2);
        applyStimulus(MULT, 32'd9, 32'd9);
        for (int i = 0; i < 9; i++) tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        checkOutput("abort_calc_busy", Busy, 0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done) doneSeen++;
            tick();
        end
        checkOutput("abort_calc_no_done", doneSeen, 0);
        checkOutput("abort_calc_hilo", {Hi, Lo}, {32'd1, 32'd2});

        // Abort during FIX.
        applyStimulus(MULT, 32'd3, 32'd3);
        for (int i = 0; i < 32; i++) tick();
        checkOutput("fix_still_busy", Busy, 1);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        checkOutput("abort_fix_busy_done", {Busy, Done}, 2'b00);
        checkOutput("abort_fix_hilo", {Hi, Lo}, {32'd1, 32'd2});

        // Reset mid-multiply, then a clean multiply.
        applyStimulus(MULT, 32'd9, 32'd9);
        for (int i = 0; i < 19; i++) tick();
        Rst_n = 1'b0;
        #1;
        checkOutput("midreset_hilo", {Hi, Lo}, 64'h0);
        checkOutput("midreset_busy_done", {Busy, Done}, 2'b00);
        #2 Rst_n = 1'b1;
        tick();
        runMul("after_reset", MULT, 32'd2, 32'd3, 32'd0, 32'd6);
        mhi = 32'd0; mlo = 32'd6;

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            if (rop >= MULT && rop <= MULTU) begin
                e = refModel(rop, ra, rb, {mhi, mlo});
                mhi = e[63:32]; mlo = e[31:0];
                runMul($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, mhi, mlo);
            end else begin
                if (rop == MTHI) mhi = ra;
                if (rop == MTLO) mlo = ra;
                runSimple($sformatf("rand%0d_op%0d", i, rop), rop, ra, mhi, mlo);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; HI and LO are each WIDTH bits.
REQ-002 SHALL have ports: Clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have ports: Rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: Start  in  1  request pulse; Op and operands are valid when Start=1.
REQ-005 SHALL have ports: Op  in  4  0 NOP, 1 MTHI, 2 MTLO, 3 MULT (signed), 4 MADD (signed), 5 MSUB (signed), 6 MULTU; codes 7-15 are NOP.
REQ-006 SHALL have ports: inA, inB  in  WIDTH each  operands; MTHI/MTLO use inA only.
REQ-007 SHALL have ports: Abort  in  1  pipeline flush; cancels an in-flight multiply.
REQ-008 SHALL have ports: Busy  out  1  multiply in progress; the pipeline stalls HI/LO readers and new Start.
REQ-009 SHALL have ports: Done  out  1  one-cycle pulse when a multiply result is committed.
REQ-010 SHALL have ports: Hi, Lo  out  WIDTH each  architectural HI/LO registers.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and FIX.
REQ-012 In IDLE, Start with MTHI/MTLO SHALL write inA to Hi/Lo at that edge, stay in IDLE, and never raise Busy or Done.
REQ-013 In IDLE, Start with Op 3-6 SHALL latch operands and Op, load a 6-bit counter with 32, and enter CALC.
REQ-014 Signed ops SHALL latch operand magnitudes and the result sign inA[31]^inB[31]; MULTU SHALL latch operands unchanged with sign 0.
REQ-015 CALC SHALL perform one unsigned shift-add step per cycle (64-bit partial product), decrement the counter, and go to FIX on the cycle the counter reaches 0.
REQ-016 FIX SHALL negate the product if the sign bit is set, then apply the Op: MULT/MULTU write {Hi,Lo}=P; MADD writes {Hi,Lo}+P; MSUB writes {Hi,Lo}-P. All arithmetic is 64-bit, wraps modulo 2^64 and has no overflow flag.
REQ-017 Timing: Start is sampled at edge E0, Busy=1 from E0 through E33 (33 cycles), Hi/Lo update at E33, Done=1 for exactly the cycle after E33, and the FSM is back in IDLE.
REQ-018 Start while Busy=1 SHALL be ignored, including MTHI/MTLO; a Start in the Done cycle SHALL be accepted normally.
REQ-019 Abort SHALL return the FSM to IDLE at the next edge from CALC or FIX, leave Hi/Lo unchanged, and not pulse Done; Abort in IDLE SHALL have no effect, and Abort has priority over a same-cycle Start.
REQ-020 Hi and Lo SHALL be registered outputs with no combinational path from the inputs.

Reset
REQ-021 Rst_n=0 SHALL asynchronously force the state to IDLE, the counter to 0, Hi=0, Lo=0, Busy=0, Done=0 and clear all latched operands.
REQ-022 Reset during CALC/FIX SHALL discard the operation; the first accepted Start after Rst_n deasserts SHALL behave per REQ-017.

Structure
REQ-023 Op code constants and FSM state encodings SHALL live in the shared package hilo_pkg.
REQ-024 The shift-add datapath (operand and partial-product registers, counter) SHALL be the sub-module mult_seq32; hilo_muldiv_ctrl holds the FSM, sign fix-up, accumulate logic and the HI/LO registers.

Verification
REQ-025 Reset, then MTHI inA=0xDEADBEEF followed by MTLO inA=0x12345678 -> Hi=0xDEADBEEF and Lo=0x12345678 after the two edges; Busy and Done stay 0.
REQ-026 MULT inA=0xFFFFFFFF (-1), inB=7 -> Busy for 33 cycles, then Done for 1 cycle, Hi=0xFFFFFFFF, Lo=0xFFFFFFF9; MULTU with the same operands -> Hi=0x00000006, Lo=0xFFFFFFF9.
REQ-027 Hi=0, Lo=10, then MADD 3*4 -> Lo=22; then MSUB 5*5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFD (-3).
REQ-028 MULT 0x80000000*0x80000000 -> Hi=0x40000000, Lo=0; a second Start issued while Busy is ignored, and the result is unaffected.
REQ-029 Hi/Lo preset to 1/2, start MULT 9*9, assert Abort 10 cycles later -> Busy drops the next cycle, no Done, Hi/Lo=1/2; repeat with Rst_n pulsed at cycle 20 instead -> Hi=Lo=0, and a following MULT 2*3 gives Lo=6.
